// File: rtl/axil_cmd_master.sv
// AXI4-Lite master command engine: queues read/write commands and runs them one at a time on the bus.
// Optional per-transaction watchdog enabled by defining AXIL_CMD_TIMEOUT_EN.
module axil_cmd_master #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                           i_axi_aclk_100MHZ,
  input  logic                           i_axi_rst,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic                           i_cmd_write,
  input  logic [ADDR_W-1:0]              i_cmd_addr,
  input  logic [DATA_W-1:0]              i_cmd_wdata,
  input  logic [DATA_W/8-1:0]            i_cmd_wstrb,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic                           o_rsp_write,
  output logic [DATA_W-1:0]              o_rsp_rdata,
  output logic [1:0]                     o_rsp_resp,
  output logic                           o_rsp_timeout,
  output logic [$clog2(CMD_DEPTH):0]     o_cmd_count,
  output logic                           o_busy,
  output logic [ADDR_W-1:0]              o_axi_awaddr,
  output logic                           o_axi_awvalid,
  input  logic                           i_axi_awready,
  output logic [DATA_W-1:0]              o_axi_wdata,
  output logic [DATA_W/8-1:0]            o_axi_wstrb,
  output logic                           o_axi_wvalid,
  input  logic                           i_axi_wready,
  input  logic                           i_axi_bvalid,
  input  logic [1:0]                     i_axi_bresp,
  output logic                           o_axi_bready,
  output logic [ADDR_W-1:0]              o_axi_araddr,
  output logic                           o_axi_arvalid,
  input  logic                           i_axi_arready,
  input  logic [DATA_W-1:0]              i_axi_rdata,
  input  logic [1:0]                     i_axi_rresp,
  input  logic                           i_axi_rvalid,
  output logic                           o_axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ENT_W  = 1 + ADDR_W + DATA_W + STRB_W;

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("DATA_W must be 32 or 64");
  end
  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("CMD_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;
  state_t state, state_nxt;

  logic [ENT_W-1:0] fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             cmd_ready_q;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  logic awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic aw_done, w_done;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic rsp_valid_q, rsp_write_q, rsp_timeout_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [1:0] rsp_resp_q;
  logic aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire;
  logic tmo_hit, tmo_exit;

  assign push = i_cmd_valid && cmd_ready_q;
  assign pop  = (state == IDLE) && (count != '0);
  assign head = fifo_mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (!push && pop) count_nxt = count - CNT_W'(1);
  end

  // Ready is registered from the next occupancy, so a full FIFO never accepts even while popping.
  always_ff @(posedge i_axi_aclk_100MHZ) begin
    if (i_axi_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_nxt;
      cmd_ready_q <= (count_nxt != CNT_W'(CMD_DEPTH));
    end
  end

  always_ff @(posedge i_axi_aclk_100MHZ) begin
    if (push) fifo_mem[wr_ptr] <= {i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_wstrb};
  end

  assign aw_fire  = awvalid_q && i_axi_awready;
  assign w_fire   = wvalid_q && i_axi_wready;
  assign b_fire   = bready_q && i_axi_bvalid;
  assign ar_fire  = arvalid_q && i_axi_arready;
  assign r_fire   = rready_q && i_axi_rvalid;
  assign rsp_fire = rsp_valid_q && i_rsp_ready;

`ifdef AXIL_CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Saturates at the limit so a handshake that wins the race cannot wrap the counter.
  always_ff @(posedge i_axi_aclk_100MHZ) begin
    if (i_axi_rst || state == IDLE) begin
      tmo_cnt <= '0;
    end else if (state != RSP && tmo_cnt != TMO_W'(TIMEOUT_CYC)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit = (state != IDLE) && (state != RSP) && (tmo_cnt == TMO_W'(TIMEOUT_CYC));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_axi_aclk_100MHZ) begin
    if (i_axi_rst) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmo_exit  = 1'b0;
    case (state)
      IDLE:    if (pop) state_nxt = head[ENT_W-1] ? WR_AW_W : RD_AR;
      WR_AW_W: begin
        if ((aw_done || aw_fire) && (w_done || w_fire)) begin
          state_nxt = WR_B;
        end else if (tmo_hit && !aw_fire && !w_fire) begin
          state_nxt = RSP;
          tmo_exit  = 1'b1;
        end
      end
      WR_B: begin
        if (b_fire)       state_nxt = RSP;
        else if (tmo_hit) begin state_nxt = RSP; tmo_exit = 1'b1; end
      end
      RD_AR: begin
        if (ar_fire)      state_nxt = RD_R;
        else if (tmo_hit) begin state_nxt = RSP; tmo_exit = 1'b1; end
      end
      RD_R: begin
        if (r_fire)       state_nxt = RSP;
        else if (tmo_hit) begin state_nxt = RSP; tmo_exit = 1'b1; end
      end
      RSP:     if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request valids launch the cycle after the command is latched; B/R readies assert on entry.
  always_ff @(posedge i_axi_aclk_100MHZ) begin
    if (i_axi_rst) begin
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      awvalid_q   <= (state == WR_AW_W) && (state_nxt == WR_AW_W) && !aw_done && !aw_fire;
      wvalid_q    <= (state == WR_AW_W) && (state_nxt == WR_AW_W) && !w_done && !w_fire;
      arvalid_q   <= (state == RD_AR) && (state_nxt == RD_AR);
      bready_q    <= (state_nxt == WR_B);
      rready_q    <= (state_nxt == RD_R);
      rsp_valid_q <= (state == RSP) && !rsp_fire;
      if (pop) begin
        addr_q        <= head[ENT_W-2 -: ADDR_W];
        wdata_q       <= head[STRB_W +: DATA_W];
        wstrb_q       <= head[STRB_W-1:0];
        aw_done       <= 1'b0;
        w_done        <= 1'b0;
        rsp_write_q   <= head[ENT_W-1];
        rsp_rdata_q   <= '0;
        rsp_resp_q    <= 2'b00;
        rsp_timeout_q <= 1'b0;
      end else begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
      if (b_fire) rsp_resp_q <= i_axi_bresp;
      if (r_fire) begin
        rsp_rdata_q <= i_axi_rdata;
        rsp_resp_q  <= i_axi_rresp;
      end
      if (tmo_exit) begin
        rsp_resp_q    <= 2'b10;
        rsp_timeout_q <= 1'b1;
        rsp_rdata_q   <= '0;
      end
    end
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_cmd_count   = count;
  assign o_busy        = (state != IDLE) || (count != '0);
  assign o_axi_awaddr  = addr_q;
  assign o_axi_awvalid = awvalid_q;
  assign o_axi_wdata   = wdata_q;
  assign o_axi_wstrb   = wstrb_q;
  assign o_axi_wvalid  = wvalid_q;
  assign o_axi_bready  = bready_q;
  assign o_axi_araddr  = addr_q;
  assign o_axi_arvalid = arvalid_q;
  assign o_axi_rready  = rready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_write   = rsp_write_q;
  assign o_rsp_rdata   = rsp_rdata_q;
  assign o_rsp_resp    = rsp_resp_q;
  assign o_rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a small configurable AXI-Lite slave model.
module tb_axil_cmd_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [2:0]  cmd_count;
  logic        busy;
  logic [3:0]  awaddr, araddr, wstrb;
  logic [31:0] wdata, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axil_cmd_master #(.ADDR_W(4), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT_CYC(8)) dut (
    .i_axi_aclk_100MHZ(clk), .i_axi_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_write(rsp_write),
    .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_rsp_timeout(rsp_timeout),
    .o_cmd_count(cmd_count), .o_busy(busy),
    .o_axi_awaddr(awaddr), .o_axi_awvalid(awvalid), .i_axi_awready(awready),
    .o_axi_wdata(wdata), .o_axi_wstrb(wstrb), .o_axi_wvalid(wvalid), .i_axi_wready(wready),
    .i_axi_bvalid(bvalid), .i_axi_bresp(bresp), .o_axi_bready(bready),
    .o_axi_araddr(araddr), .o_axi_arvalid(arvalid), .i_axi_arready(arready),
    .i_axi_rdata(rdata), .i_axi_rresp(rresp), .i_axi_rvalid(rvalid), .o_axi_rready(rready)
  );

  // Slave model: per-channel wait counts, optional permanent AW stall.
  int          aw_wait = 0, w_wait = 0, r_wait = 0;
  bit          aw_never = 1'b0;
  logic [1:0]  slv_bresp = 2'b00, slv_rresp = 2'b00;
  logic [31:0] slv_rbase = '0;
  int          aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_count = 0;
  logic        aw_got = 1'b0, w_got = 1'b0, r_pend = 1'b0;
  logic [3:0]  ar_lat = '0, cap_awaddr = '0, cap_araddr = '0, cap_wstrb = '0;
  logic [31:0] cap_wdata = '0;

  assign awready = awvalid && !aw_never && (aw_cnt >= aw_wait);
  assign wready  = wvalid && (w_cnt >= w_wait);
  assign arready = arvalid;
  assign bresp   = slv_bresp;
  assign rresp   = slv_rresp;
  assign rdata   = rvalid ? (slv_rbase + 32'(ar_lat)) : 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (awvalid && awready) begin aw_got <= 1'b1; cap_awaddr <= awaddr; end
      if (wvalid && wready) begin w_got <= 1'b1; cap_wdata <= wdata; cap_wstrb <= wstrb; end
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bvalid && bready) begin bvalid <= 1'b0; b_count <= b_count + 1; end
      if (arvalid && arready) begin
        cap_araddr <= araddr;
        ar_lat     <= araddr;
        if (r_wait == 0) rvalid <= 1'b1;
        else begin r_pend <= 1'b1; r_cnt <= 1; end
      end else if (r_pend) begin
        if (r_cnt >= r_wait) begin rvalid <= 1'b1; r_pend <= 1'b0; end
        else r_cnt <= r_cnt + 1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (n >= 50) check("push_ready_wait", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    check({tag, "_rsp_seen"}, 64'(rsp_valid), 64'd1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic wait_sig(input string tag, ref logic sig);
    int n = 0;
    while (!sig && n < 100) begin tick(); n++; end
    check({tag, "_seen"}, 64'(sig), 64'd1);
  endtask

  logic        exp_w [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0]  exp_a [5]  = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6};
  int          b0;

  initial begin
    // Reset state
    tick(); tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_count", 64'(cmd_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'd0);
    check("rst_addr_data", 64'({awaddr, araddr, wdata, wstrb}), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 64'(cmd_ready), 64'd1);

    // Zero-wait write, cycle-exact
    push(1'b1, 4'h4, 32'h50, 4'hF);
    check("w0_n0_awvalid", 64'(awvalid), 64'd0);
    tick();
    check("w0_n1_busy", 64'(busy), 64'd1);
    check("w0_n1_awvalid", 64'(awvalid), 64'd0);
    tick();
    check("w0_n2_valids", 64'({awvalid, wvalid, bready}), 64'b110);
    check("w0_n2_fields", 64'({awaddr, wdata, wstrb}), 64'({4'h4, 32'h50, 4'hF}));
    tick();
    check("w0_n3_valids", 64'({awvalid, wvalid, bready}), 64'b001);
    tick();
    check("w0_n4_bready_rsp", 64'({bready, rsp_valid}), 64'b00);
    tick();
    check("w0_n5_rsp_valid", 64'(rsp_valid), 64'd1);
    check("w0_rsp_fields", 64'({rsp_write, rsp_timeout, rsp_resp, rsp_rdata}), 64'({1'b1, 1'b0, 2'b00, 32'h0}));
    check("w0_slave_cap", 64'({cap_awaddr, cap_wdata, cap_wstrb}), 64'({4'h4, 32'h50, 4'hF}));
    take_rsp();
    check("w0_after_rsp", 64'({rsp_valid, busy}), 64'b00);

    // Skewed write: W accepted three cycles before AW
    aw_wait = 3; w_wait = 0; b0 = b_count;
    push(1'b1, 4'hC, 32'hA5A5_0001, 4'h3);
    wait_sig("skw_wvalid", wvalid);
    tick();
    check("skw_w_dropped", 64'({wvalid, awvalid}), 64'b01);
    tick();
    check("skw_aw_held", 64'({wvalid, awvalid}), 64'b01);
    wait_rsp("skw");
    check("skw_single_b", 64'(b_count - b0), 64'd1);
    check("skw_resp", 64'({rsp_write, rsp_resp}), 64'({1'b1, 2'b00}));
    check("skw_slave_cap", 64'({cap_awaddr, cap_wdata, cap_wstrb}), 64'({4'hC, 32'hA5A5_0001, 4'h3}));
    take_rsp();
    aw_wait = 0;

    // Non-OKAY write response is passed through
    slv_bresp = 2'b10;
    push(1'b1, 4'h0, 32'h1, 4'h1);
    wait_rsp("slverr");
    check("slverr_resp", 64'({rsp_resp, rsp_timeout}), 64'({2'b10, 1'b0}));
    take_rsp();
    slv_bresp = 2'b00;

    // Read with four wait cycles on R
    r_wait = 4; slv_rbase = 32'h8;
    push(1'b0, 4'h8, 32'hFFFF_FFFF, 4'hF);
    wait_sig("rd_arvalid", arvalid);
    check("rd_no_early_ready", 64'({rready, bready}), 64'b00);
    wait_rsp("rd");
    check("rd_rsp", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'({1'b0, 2'b00, 32'h10}));
    check("rd_araddr", 64'(cap_araddr), 64'h8);
    take_rsp();

    // FIFO full with stalled response, then in-order drain
    r_wait = 0; slv_rbase = 32'h1000_0000;
    for (int i = 0; i < 5; i++) push(exp_w[i], exp_a[i], 32'h33, 4'hF);
    check("full_ready", 64'(cmd_ready), 64'd0);
    check("full_count", 64'(cmd_count), 64'd4);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h7;
    tick(); tick(); tick();
    check("full_hold_count", 64'(cmd_count), 64'd4);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_rsp($sformatf("drain%0d", i));
      check($sformatf("drain%0d_write", i), 64'(rsp_write), 64'(exp_w[i]));
      check($sformatf("drain%0d_rdata", i), 64'(rsp_rdata),
            exp_w[i] ? 64'd0 : 64'(32'h1000_0000 + 32'(exp_a[i])));
      take_rsp();
      if (i == 0) begin
        check("b2b_h0_arvalid", 64'(arvalid), 64'd0);
        tick();
        check("b2b_h1_arvalid", 64'(arvalid), 64'd0);
        check("b2b_h1_count", 64'({cmd_ready, cmd_count}), 64'({1'b1, 3'd3}));
        tick();
        check("b2b_h2_arvalid", 64'(arvalid), 64'd1);
      end
    end
    tick(); tick();
    check("drain_idle", 64'({busy, cmd_count}), 64'd0);

    // Stalled AW: watchdog response or indefinite wait
    aw_never = 1'b1;
    push(1'b1, 4'h2, 32'hDEAD, 4'hF);
    wait_sig("stall_awvalid", awvalid);
`ifdef AXIL_CMD_TIMEOUT_EN
    repeat (7) tick();
    check("tmo_aw_still_high", 64'(awvalid), 64'd1);
    tick();
    check("tmo_valids_low", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    wait_rsp("tmo");
    check("tmo_rsp", 64'({rsp_write, rsp_timeout, rsp_resp, rsp_rdata}), 64'({1'b1, 1'b1, 2'b10, 32'h0}));
    take_rsp();
    aw_never = 1'b0;
`else
    repeat (20) tick();
    check("stall_aw_held", 64'({awvalid, rsp_valid}), 64'b10);
    aw_never = 1'b0;
    wait_rsp("stall");
    check("stall_rsp", 64'({rsp_timeout, rsp_resp}), 64'd0);
    take_rsp();
`endif

    // Reset in the middle of a read
    r_wait = 10; slv_rbase = 32'h0;
    push(1'b0, 4'h8, 32'h0, 4'h0);
    push(1'b1, 4'h1, 32'h0, 4'h0);
    wait_sig("mid_rready", rready);
    check("mid_count", 64'(cmd_count), 64'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_outputs", 64'({rready, rsp_valid, busy, arvalid, cmd_ready}), 64'd0);
    check("mid_rst_count", 64'({cmd_count, araddr}), 64'd0);
    rst = 1'b0;
    tick();
    check("mid_ready_back", 64'(cmd_ready), 64'd1);
    r_wait = 0; slv_rbase = 32'h100;
    push(1'b0, 4'h4, 32'h0, 4'h0);
    wait_rsp("after_rst");
    check("after_rst_rsp", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'({1'b0, 2'b00, 32'h104}));
    take_rsp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
